// File: rtl/eth_fcs_checker_pkg.sv
// Shared constants and types for the Ethernet RX FCS checker and
// the CRC-32 step that the TX side will also use.
package eth_fcs_checker_pkg;

   localparam int DATALEN = 8;
   localparam int CRC_LEN = 32;

   // IEEE 802.3 polynomial in reflected (LSB-first) form
   localparam logic [CRC_LEN-1:0] CRC_POLY_REV = 32'hEDB88320;
   // Register value left after clocking a good frame's own FCS through
   localparam logic [CRC_LEN-1:0] CRC_RESIDUE  = 32'hDEBB20E3;
   localparam logic [CRC_LEN-1:0] CRC_INIT     = 32'hFFFFFFFF;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      OVF
   } fcs_chk_state_t;

endpackage

// File: rtl/crc32_byte_step.sv
// Combinational CRC-32 update for one byte, reflected form, LSB first.
// Ports: crc_i current register, data_i byte, crc_o register after 8 steps.
module crc32_byte_step
   import eth_fcs_checker_pkg::*;
(
   input  logic [CRC_LEN-1:0] crc_i,
   input  logic [DATALEN-1:0] data_i,
   output logic [CRC_LEN-1:0] crc_o
);

   logic [CRC_LEN-1:0] c;

   always_comb begin
      // Fold the whole byte in first; each shift then consumes one bit
      c = crc_i ^ {{(CRC_LEN-DATALEN){1'b0}}, data_i};
      for (int i = 0; i < DATALEN; i++) begin
         c = c[0] ? ((c >> 1) ^ CRC_POLY_REV) : (c >> 1);
      end
      crc_o = c;
   end

endmodule

// File: rtl/eth_fcs_checker.sv
// RX FCS checker: bytewise CRC-32 against the residue, length and PHY
// error tracking, 1-cycle byte forwarding and a registered per-frame status.
// Ports: clk/rst (sync, active-high); s_* input byte stream (no stall);
// m_* forwarded stream; frame_done pulse with frame_ok, fcs_err, len_err,
// phy_err and byte_cnt held until the next frame_done.
// Build option: FCS_STRIP_EN withholds the 4 FCS bytes from m_*.
module eth_fcs_checker
   import eth_fcs_checker_pkg::*;
#(
   parameter int MIN_LEN = 64,
   parameter int MAX_LEN = 1518
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        s_valid,
   input  logic [7:0]  s_data,
   input  logic        s_last,
   input  logic        s_err,
   output logic        m_valid,
   output logic [7:0]  m_data,
   output logic        m_last,
   output logic        frame_done,
   output logic        frame_ok,
   output logic        fcs_err,
   output logic        len_err,
   output logic        phy_err,
   output logic [11:0] byte_cnt
);

   localparam logic [11:0] MIN_L   = 12'(MIN_LEN);
   localparam logic [11:0] MAX_L   = 12'(MAX_LEN);
   localparam logic [11:0] CNT_SAT = 12'hFFF;

   fcs_chk_state_t state_q;
   logic [31:0] crc_q, crc_d, crc_step;
   logic [11:0] cnt_q, cnt_d;
   logic        phy_q, phy_d;
   logic        ovf_hit, in_ovf;
   logic        fcs_bad, len_bad;

`ifdef FCS_STRIP_EN
   logic [31:0] buf_q;
   logic [2:0]  fill_q;
   logic        buf_full;
   assign buf_full = (fill_q == 3'd4);
`endif

   crc32_byte_step u_step (
      .crc_i  (crc_q),
      .data_i (s_data),
      .crc_o  (crc_step)
   );

   // crc_q/cnt_q are back at init/0 whenever the FSM is IDLE, so the
   // first byte of a frame needs no special path.
   always_comb begin
      cnt_d   = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 12'd1;
      ovf_hit = (state_q != OVF) && (cnt_d > MAX_L);
      in_ovf  = (state_q == OVF) || ovf_hit;
      crc_d   = in_ovf ? crc_q : crc_step;
      phy_d   = phy_q | s_err;
      fcs_bad = (crc_d != CRC_RESIDUE);
      len_bad = (cnt_d < MIN_L) || (cnt_d > MAX_L);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         crc_q      <= CRC_INIT;
         cnt_q      <= '0;
         phy_q      <= 1'b0;
         m_valid    <= 1'b0;
         m_data     <= '0;
         m_last     <= 1'b0;
         frame_done <= 1'b0;
         frame_ok   <= 1'b0;
         fcs_err    <= 1'b0;
         len_err    <= 1'b0;
         phy_err    <= 1'b0;
         byte_cnt   <= '0;
`ifdef FCS_STRIP_EN
         buf_q      <= '0;
         fill_q     <= '0;
`endif
      end else begin
         frame_done <= 1'b0;
         m_valid    <= 1'b0;
         m_last     <= 1'b0;

         if (s_valid) begin
            if (s_last) begin
               frame_done <= 1'b1;
               frame_ok   <= ~(fcs_bad | len_bad | phy_d);
               fcs_err    <= fcs_bad;
               len_err    <= len_bad;
               phy_err    <= phy_d;
               byte_cnt   <= cnt_d;
               state_q    <= IDLE;
               crc_q      <= CRC_INIT;
               cnt_q      <= '0;
               phy_q      <= 1'b0;
            end else begin
               state_q <= in_ovf ? OVF : RUN;
               crc_q   <= crc_d;
               cnt_q   <= cnt_d;
               phy_q   <= phy_d;
            end
         end

`ifdef FCS_STRIP_EN
         // A byte leaves only once four newer bytes sit behind it, so
         // the trailing FCS never reaches the output.
         m_data <= buf_q[31:24];
         if (s_valid) begin
            m_valid <= buf_full & ~in_ovf;
            m_last  <= buf_full & ~in_ovf & s_last;
            if (s_last) begin
               buf_q  <= '0;
               fill_q <= '0;
            end else begin
               buf_q  <= {buf_q[23:0], s_data};
               fill_q <= buf_full ? fill_q : fill_q + 3'd1;
            end
         end
`else
         m_data <= s_data;
         if (s_valid) begin
            m_valid <= ~in_ovf;
            m_last  <= ~in_ovf & s_last;
         end
`endif
      end
   end

endmodule

// File: tb/tb_eth_fcs_checker.sv
// Bench for eth_fcs_checker: two instances (MIN_LEN=4 and default)
// share one stimulus; expected bytes and status come from a queue model.
module tb_eth_fcs_checker;

   localparam logic [31:0] POLY = 32'hEDB88320;
   localparam logic [31:0] RES  = 32'hDEBB20E3;
   localparam int          MAXL = 1518;

   logic clk = 1'b0;
   logic rst;
   logic s_valid, s_last, s_err;
   logic [7:0] s_data;

   logic a_mv, a_ml, a_fd, a_ok, a_fe, a_le, a_pe;
   logic [7:0] a_md;
   logic [11:0] a_bc;
   logic b_mv, b_ml, b_fd, b_ok, b_fe, b_le, b_pe;
   logic [7:0] b_md;
   logic [11:0] b_bc;

   always #5 clk = ~clk;

   eth_fcs_checker #(.MIN_LEN(4)) u_dut_a (
      .clk(clk), .rst(rst),
      .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_err(s_err),
      .m_valid(a_mv), .m_data(a_md), .m_last(a_ml),
      .frame_done(a_fd), .frame_ok(a_ok), .fcs_err(a_fe),
      .len_err(a_le), .phy_err(a_pe), .byte_cnt(a_bc)
   );

   eth_fcs_checker u_dut_b (
      .clk(clk), .rst(rst),
      .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_err(s_err),
      .m_valid(b_mv), .m_data(b_md), .m_last(b_ml),
      .frame_done(b_fd), .frame_ok(b_ok), .fcs_err(b_fe),
      .len_err(b_le), .phy_err(b_pe), .byte_cnt(b_bc)
   );

   typedef struct {
      logic [7:0] d;
      logic       l;
   } dexp_t;

   typedef struct {
      logic        ok, fe, le, pe, ml;
      logic [11:0] cnt;
      int          cyc;
   } sexp_t;

   dexp_t qd0[$], qd1[$];
   sexp_t qs0[$], qs1[$];
   logic [7:0] fr[$];
   logic [15:0] held[2];
   int total = 0;
   int bad = 0;
   int cyc = 0;
   logic rst_seen = 1'b0;

   always @(posedge clk) begin
      cyc      <= cyc + 1;
      rst_seen <= rst;
   end

   task automatic check_eq(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Serial LFSR form: one feedback bit per wire bit
   function automatic logic [31:0] crc_upd(input logic [31:0] c,
                                           input logic [7:0] b);
      for (int i = 0; i < 8; i++) begin
         if (c[0] ^ b[i]) c = (c >> 1) ^ POLY;
         else             c = c >> 1;
      end
      return c;
   endfunction

   task automatic build_t1();
      string s;
      s = "123456789";
      fr.delete();
      for (int i = 0; i < 9; i++) fr.push_back(s[i]);
      fr.push_back(8'h26);
      fr.push_back(8'h39);
      fr.push_back(8'hF4);
      fr.push_back(8'hCB);
   endtask

   task automatic add_fcs();
      logic [31:0] c;
      c = 32'hFFFFFFFF;
      foreach (fr[i]) c = crc_upd(c, fr[i]);
      c = ~c;
      for (int i = 0; i < 4; i++) fr.push_back(c[8*i +: 8]);
   endtask

   task automatic expect_fwd(input int n, input bit complete);
      int lim;
      dexp_t e;
      lim = (n > MAXL) ? MAXL : n;
`ifdef FCS_STRIP_EN
      lim = lim - 4;
`endif
      for (int i = 0; i < lim; i++) begin
         e.d = fr[i];
         e.l = complete && (n <= MAXL) && (i == lim - 1);
         qd0.push_back(e);
         qd1.push_back(e);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1 s_valid = 1'b0;
         s_last = 1'b0;
         s_err  = 1'b0;
      end
   endtask

   task automatic send(input int err_at, input bit gaps);
      int n, cnt;
      bit ovf, phy;
      logic [31:0] c;
      sexp_t sa, sb;
      n   = fr.size();
      c   = 32'hFFFFFFFF;
      cnt = 0;
      ovf = 0;
      phy = 0;
      for (int i = 0; i < n; i++) begin
         int nc;
         nc = (cnt == 4095) ? cnt : cnt + 1;
         if (!ovf && nc > MAXL) ovf = 1;
         if (!ovf) c = crc_upd(c, fr[i]);
         cnt = nc;
         if (i == err_at) phy = 1;
      end
      expect_fwd(n, 1'b1);
      for (int i = 0; i < n; i++) begin
         if (gaps && (i % 5 == 3)) begin
            @(posedge clk);
            #1 s_valid = 1'b0;
            s_last = 1'b1;
            s_err  = 1'b0;
         end
         @(posedge clk);
         #1 s_valid = 1'b1;
         s_data = fr[i];
         s_err  = (i == err_at);
         s_last = (i == n - 1);
      end
      sa.fe  = (c != RES);
      sa.pe  = phy;
      sa.cnt = 12'(cnt);
      sa.cyc = cyc + 1;
`ifdef FCS_STRIP_EN
      sa.ml  = (n <= MAXL) && (n >= 5);
`else
      sa.ml  = (n <= MAXL);
`endif
      sb     = sa;
      sa.le  = (cnt < 4) || (cnt > MAXL);
      sb.le  = (cnt < 64) || (cnt > MAXL);
      sa.ok  = !(sa.fe || sa.le || sa.pe);
      sb.ok  = !(sb.fe || sb.le || sb.pe);
      qs0.push_back(sa);
      qs1.push_back(sb);
   endtask

   // k bytes go out, byte k+1 is presented together with reset
   task automatic abort_frame(input int k);
      expect_fwd(k, 1'b0);
      for (int i = 0; i < k; i++) begin
         @(posedge clk);
         #1 s_valid = 1'b1;
         s_data = fr[i];
         s_err  = 1'b0;
         s_last = 1'b0;
      end
      @(posedge clk);
      #1 s_data = fr[k];
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      s_valid = 1'b0;
   endtask

   task automatic mon(input int k, input logic mv, input logic [7:0] md,
                      input logic ml, input logic fd, input logic fo,
                      input logic fe, input logic le, input logic pe,
                      input logic [11:0] bc);
      string nm;
      dexp_t e;
      sexp_t s;
      bit have;
      nm = (k == 0) ? "a" : "b";
      if (rst_seen) held[k] = '0;
      if (mv === 1'b1) begin
         have = (k == 0) ? (qd0.size() > 0) : (qd1.size() > 0);
         if (!have) begin
            check_eq({nm, "_extra_byte"}, 32'(md), 32'hFFFF);
         end else begin
            if (k == 0) e = qd0.pop_front();
            else        e = qd1.pop_front();
            check_eq({nm, "_m_data"}, 32'(md), 32'(e.d));
            check_eq({nm, "_m_last"}, 32'(ml), 32'(e.l));
         end
      end
      if (fd === 1'b1) begin
         have = (k == 0) ? (qs0.size() > 0) : (qs1.size() > 0);
         if (!have) begin
            check_eq({nm, "_extra_done"}, 32'(fd), 32'h0);
         end else begin
            if (k == 0) s = qs0.pop_front();
            else        s = qs1.pop_front();
            check_eq({nm, "_done_cyc"}, 32'(cyc), 32'(s.cyc));
            check_eq({nm, "_frame_ok"}, 32'(fo), 32'(s.ok));
            check_eq({nm, "_fcs_err"}, 32'(fe), 32'(s.fe));
            check_eq({nm, "_len_err"}, 32'(le), 32'(s.le));
            check_eq({nm, "_phy_err"}, 32'(pe), 32'(s.pe));
            check_eq({nm, "_byte_cnt"}, 32'(bc), 32'(s.cnt));
            check_eq({nm, "_done_mlast"}, 32'(ml), 32'(s.ml));
            held[k] = {s.ok, s.fe, s.le, s.pe, s.cnt};
         end
      end else if (fd === 1'b0) begin
         check_eq({nm, "_status_hold"}, 32'({fo, fe, le, pe, bc}),
                  32'(held[k]));
      end
   endtask

   logic mon_en = 1'b0;

   always @(negedge clk) begin
      if (mon_en) begin
         mon(0, a_mv, a_md, a_ml, a_fd, a_ok, a_fe, a_le, a_pe, a_bc);
         mon(1, b_mv, b_md, b_ml, b_fd, b_ok, b_fe, b_le, b_pe, b_bc);
      end
   end

   initial begin
      held[0] = '0;
      held[1] = '0;
      rst     = 1'b1;
      s_valid = 1'b0;
      s_last  = 1'b0;
      s_err   = 1'b0;
      s_data  = 8'h00;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("a_reset", 32'({a_mv, a_md, a_ml, a_fd, a_ok, a_fe, a_le,
                               a_pe, a_bc}), 32'h0);
      check_eq("b_reset", 32'({b_mv, b_md, b_ml, b_fd, b_ok, b_fe, b_le,
                               b_pe, b_bc}), 32'h0);
      mon_en = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;

      // check value, with idle gaps and stray s_last inside the frame
      build_t1();
      send(-1, 1'b1);
      idle(3);

      // corrupted payload byte
      build_t1();
      fr[4] = 8'h34;
      send(-1, 1'b0);
      idle(2);

      // 64-byte minimum frame, then a 60-byte runt
      fr.delete();
      repeat (60) fr.push_back(8'h00);
      add_fcs();
      send(-1, 1'b0);
      idle(2);
      fr.delete();
      repeat (56) fr.push_back(8'h00);
      add_fcs();
      send(-1, 1'b0);
      idle(2);

      // oversize frame: forwarding stops at MAX_LEN
      fr.delete();
      repeat (1515) fr.push_back(8'($urandom_range(0, 255)));
      add_fcs();
      send(-1, 1'b0);
      idle(2);

      // back-to-back frames, PHY error on byte 3 of the second
      build_t1();
      send(-1, 1'b0);
      send(2, 1'b0);
      idle(2);

      // reset mid-frame, then a clean frame
      build_t1();
      abort_frame(6);
      send(-1, 1'b0);
      idle(6);

      check_eq("a_bytes_left", 32'(qd0.size()), 32'h0);
      check_eq("b_bytes_left", 32'(qd1.size()), 32'h0);
      check_eq("a_done_left", 32'(qs0.size()), 32'h0);
      check_eq("b_done_left", 32'(qs1.size()), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
